// File: rtl/clock_gen_pkg.sv
// rtl/clock_gen_pkg.sv - shared types and defaults for the clock divider bank
package clock_gen_pkg;

   localparam int CG_DIV_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_RESET   = 2'd0,
      ST_LOCKING = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_PWRDN   = 2'd3
   } cg_state_e;

   typedef struct packed {
      logic [CG_DIV_WIDTH-1:0] divide;
      logic [CG_DIV_WIDTH-1:0] phase;
   } chan_cfg_t;

endpackage

// File: rtl/clock_divider_channel.sv
// rtl/clock_divider_channel.sv - one divider channel: period counter plus registered level and strobe
module clock_divider_channel
   import clock_gen_pkg::*;
#(
   parameter int DIV_WIDTH = CG_DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic [DIV_WIDTH-1:0] divide,
   input  logic [DIV_WIDTH-1:0] phase,
   output logic                 clk_out,
   output logic                 strobe
);

   logic [DIV_WIDTH-1:0] div_eff;
   logic [DIV_WIDTH-1:0] last_cnt;
   logic [DIV_WIDTH-1:0] eff_phase;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic                 clk_out_q, clk_out_d;
   logic                 strobe_q, strobe_d;

   // Next counter and output values; a zero divide behaves as divide-by-one and the
   // strobe phase is clamped to the last count of the period.
   always_comb begin
      div_eff   = (divide == '0) ? DIV_WIDTH'(1) : divide;
      last_cnt  = div_eff - DIV_WIDTH'(1);
      eff_phase = (phase > last_cnt) ? last_cnt : phase;
      cnt_d     = '0;
      clk_out_d = 1'b0;
      strobe_d  = 1'b0;
      if (run) begin
         cnt_d     = (cnt_q >= last_cnt) ? '0 : cnt_q + DIV_WIDTH'(1);
         clk_out_d = (div_eff == DIV_WIDTH'(1)) ? 1'b1 : (cnt_q < (div_eff >> 1));
         strobe_d  = (cnt_q == eff_phase);
      end
   end

   // Counter and output registers; held at zero whenever the channel is not running.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         clk_out_q <= 1'b0;
         strobe_q  <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         clk_out_q <= clk_out_d;
         strobe_q  <= strobe_d;
      end
   end

   assign clk_out = clk_out_q;
   assign strobe  = strobe_q;

endmodule

// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - lock sequencing, channel configuration and divider channel array
module clock_divider_bank
   import clock_gen_pkg::*;
#(
   parameter int NUM_OUTPUTS    = 6,
   parameter int DIV_WIDTH      = CG_DIV_WIDTH,
   parameter int LOCK_CYCLES    = 64,
   parameter int DEFAULT_DIVIDE = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pwrdwn,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [3:0]             cfg_channel,
   input  logic [DIV_WIDTH-1:0]   cfg_divide,
   input  logic [DIV_WIDTH-1:0]   cfg_phase,
   output logic [NUM_OUTPUTS-1:0] clk_out,
   output logic [NUM_OUTPUTS-1:0] strobe,
   output logic                   locked
);

   localparam int LCW = $clog2(LOCK_CYCLES);

   cg_state_e      state_q, state_d;
   logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
   chan_cfg_t      cfg_q [NUM_OUTPUTS];
   logic           cfg_hit;
   logic           cfg_write;
   logic           run;

   assign locked    = (state_q == ST_LOCKED);
   assign cfg_ready = locked & ~pwrdwn;
   assign cfg_hit   = ({1'b0, cfg_channel} < 5'(NUM_OUTPUTS));
   assign cfg_write = cfg_valid & cfg_ready & cfg_hit;

   // Channels run only while the bank stays locked across this edge, so leaving LOCKED
   // clears the outputs at once and entering LOCKED starts every counter together.
   assign run = (state_q == ST_LOCKED) && (state_d == ST_LOCKED);

   // Lock sequencing: power-down overrides every other transition.
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = '0;
      unique case (state_q)
         ST_RESET:   state_d = ST_LOCKING;
         ST_LOCKING: begin
            if (lock_cnt_q == LCW'(LOCK_CYCLES - 1)) begin
               state_d = ST_LOCKED;
            end else begin
               lock_cnt_d = lock_cnt_q + LCW'(1);
            end
         end
         ST_LOCKED:  if (cfg_write) state_d = ST_LOCKING;
         ST_PWRDN:   state_d = ST_LOCKING;
         default:    state_d = ST_RESET;
      endcase
      if (pwrdwn) begin
         state_d    = ST_PWRDN;
         lock_cnt_d = '0;
      end
   end

   // State and lock counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_RESET;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   // Per-channel configuration; writes to channels that do not exist are dropped.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
         if (reset) begin
            cfg_q[i] <= '{divide: CG_DIV_WIDTH'(DEFAULT_DIVIDE), phase: '0};
         end else if (cfg_write && (cfg_channel == 4'(i))) begin
            cfg_q[i] <= '{divide: cfg_divide, phase: cfg_phase};
         end
      end
   end

   for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_ch
      clock_divider_channel #(
         .DIV_WIDTH (DIV_WIDTH)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .run     (run),
         .divide  (cfg_q[g].divide),
         .phase   (cfg_q[g].phase),
         .clk_out (clk_out[g]),
         .strobe  (strobe[g])
      );
   end

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb/tb_clock_divider_bank.sv - directed self-checking bench for clock_divider_bank
module tb_clock_divider_bank;

   localparam int NO = 6;
   localparam int DW = 8;
   localparam int LC = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          pwrdwn;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [3:0]    cfg_channel;
   logic [DW-1:0] cfg_divide;
   logic [DW-1:0] cfg_phase;
   logic [NO-1:0] clk_out;
   logic [NO-1:0] strobe;
   logic          locked;

   int n_checks = 0;
   int n_fail   = 0;

   // All channels at divide 2
   logic [5:0] p0_clk [10] = '{6'h3F, 6'h00, 6'h3F, 6'h00, 6'h3F, 6'h00, 6'h3F, 6'h00, 6'h3F, 6'h00};
   logic [5:0] p0_stb [10] = '{6'h3F, 6'h00, 6'h3F, 6'h00, 6'h3F, 6'h00, 6'h3F, 6'h00, 6'h3F, 6'h00};
   // ch0 div5 ph3, others divide 2
   logic [5:0] p2_clk [10] = '{6'h3F, 6'h01, 6'h3E, 6'h00, 6'h3E, 6'h01, 6'h3F, 6'h00, 6'h3E, 6'h00};
   logic [5:0] p2_stb [10] = '{6'h3E, 6'h00, 6'h3E, 6'h01, 6'h3E, 6'h00, 6'h3E, 6'h00, 6'h3F, 6'h00};
   // ch0 div5 ph3, ch1 div1, ch2 div4 ph3 (clamped), others divide 2
   logic [5:0] p3_clk [10] = '{6'h3F, 6'h07, 6'h3A, 6'h02, 6'h3E, 6'h07, 6'h3B, 6'h02, 6'h3E, 6'h06};
   logic [5:0] p3_stb [10] = '{6'h3A, 6'h02, 6'h3A, 6'h07, 6'h3A, 6'h02, 6'h3A, 6'h06, 6'h3B, 6'h02};

   clock_divider_bank #(
      .NUM_OUTPUTS    (NO),
      .DIV_WIDTH      (DW),
      .LOCK_CYCLES    (LC),
      .DEFAULT_DIVIDE (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pwrdwn      (pwrdwn),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_channel (cfg_channel),
      .cfg_divide  (cfg_divide),
      .cfg_phase   (cfg_phase),
      .clk_out     (clk_out),
      .strobe      (strobe),
      .locked      (locked)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called right after the edge that entered LOCKING with a zero count.
   task automatic wait_lock(input string tag);
      repeat (LC - 1) step();
      check({tag, "_still_locking"}, 32'(locked), 32'd0);
      step();
      check({tag, "_locked"}, 32'(locked), 32'd1);
   endtask

   task automatic check_seq(input string tag, input int n,
                            input logic [5:0] ec [10], input logic [5:0] es [10]);
      for (int k = 0; k < n; k++) begin
         step();
         check($sformatf("%s_clk_k%0d", tag, k), 32'(clk_out), 32'(ec[k]));
         check($sformatf("%s_stb_k%0d", tag, k), 32'(strobe), 32'(es[k]));
      end
   endtask

   task automatic send_cfg(input logic [3:0] ch, input logic [7:0] dv, input logic [7:0] ph);
      cfg_valid   = 1'b1;
      cfg_channel = ch;
      cfg_divide  = dv;
      cfg_phase   = ph;
   endtask

   initial begin
      reset       = 1'b1;
      pwrdwn      = 1'b0;
      cfg_valid   = 1'b0;
      cfg_channel = '0;
      cfg_divide  = '0;
      cfg_phase   = '0;
      repeat (3) step();
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_ready", 32'(cfg_ready), 32'd0);
      check("rst_clk", 32'(clk_out), 32'd0);
      check("rst_stb", 32'(strobe), 32'd0);

      // 1: lock from reset with default divides
      reset = 1'b0;
      step();
      wait_lock("t1");
      check("t1_clk_at_lock", 32'(clk_out), 32'd0);
      check("t1_stb_at_lock", 32'(strobe), 32'd0);
      check("t1_ready", 32'(cfg_ready), 32'd1);
      check_seq("t1", 4, p0_clk, p0_stb);

      // 2: ch0 div5 phase3
      send_cfg(4'd0, 8'd5, 8'd3);
      step();
      cfg_valid = 1'b0;
      check("t2_unlocked", 32'(locked), 32'd0);
      check("t2_ready_low", 32'(cfg_ready), 32'd0);
      check("t2_clk_off", 32'(clk_out), 32'd0);
      wait_lock("t2");
      check_seq("t2", 10, p2_clk, p2_stb);

      // 3: ch1 div0 phase7, then ch2 div4 phase9
      send_cfg(4'd1, 8'd0, 8'd7);
      step();
      cfg_valid = 1'b0;
      wait_lock("t3a");
      send_cfg(4'd2, 8'd4, 8'd9);
      step();
      cfg_valid = 1'b0;
      wait_lock("t3b");
      check_seq("t3", 8, p3_clk, p3_stb);

      // 4: write to a channel that does not exist
      send_cfg(4'd12, 8'd9, 8'd0);
      #1;
      check("t4_ready", 32'(cfg_ready), 32'd1);
      step();
      cfg_valid = 1'b0;
      check("t4_locked", 32'(locked), 32'd1);
      check("t4_clk_k8", 32'(clk_out), 32'(p3_clk[8]));
      check("t4_stb_k8", 32'(strobe), 32'(p3_stb[8]));
      step();
      check("t4_clk_k9", 32'(clk_out), 32'(p3_clk[9]));
      check("t4_stb_k9", 32'(strobe), 32'(p3_stb[9]));

      // 5: power-down for 10 cycles with a competing cfg request
      pwrdwn = 1'b1;
      send_cfg(4'd0, 8'd3, 8'd0);
      #1;
      check("t5_ready_refused", 32'(cfg_ready), 32'd0);
      step();
      check("t5_unlocked", 32'(locked), 32'd0);
      check("t5_clk_off", 32'(clk_out), 32'd0);
      check("t5_stb_off", 32'(strobe), 32'd0);
      repeat (9) step();
      check("t5_hold", 32'(locked), 32'd0);
      check("t5_hold_ready", 32'(cfg_ready), 32'd0);
      pwrdwn    = 1'b0;
      cfg_valid = 1'b0;
      step();
      wait_lock("t5");
      check_seq("t5", 10, p3_clk, p3_stb);

      // 6: reset in the middle of a relock
      send_cfg(4'd3, 8'd7, 8'd1);
      step();
      cfg_valid = 1'b0;
      repeat (20) step();
      check("t6_mid_locking", 32'(locked), 32'd0);
      reset = 1'b1;
      step();
      check("t6_rst_locked", 32'(locked), 32'd0);
      check("t6_rst_ready", 32'(cfg_ready), 32'd0);
      check("t6_rst_clk", 32'(clk_out), 32'd0);
      check("t6_rst_stb", 32'(strobe), 32'd0);
      reset = 1'b0;
      step();
      wait_lock("t6");
      check_seq("t6", 4, p0_clk, p0_stb);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
